fx3_settings_slave: RTL and testbench

Serial settings-bus receiver for the FX3 control pins (SDA on GPIF_CTL6, SCL on GPIF_CTL8), sitting directly downstream of the top-level pins and upstream of the core settings bus. It synchronises and deglitches both lines and decodes write-only, I2C-framed transactions: START, device byte, register byte, 32-bit data word, STOP. Each complete write becomes a single-cycle settings strobe with address and data. The block never drives SDA and generates no ACK, because both pins are FPGA inputs.

---
 rtl/fx3_settings_slave.sv | 136 +++++++++++++
 tb/tb_fx3_settings_slave.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fx3_settings_slave.sv
// fx3_settings_slave: deglitched I2C-framed write-only settings receiver (dev, reg, 32-bit data).
// Optional SETTINGS_BUS_TIMEOUT_EN aborts frames whose SCL stalls for TIMEOUT cycles.
`timescale 1ns/1ps
module fx3_settings_slave #(
    parameter logic [6:0] DEVICE_ADDR = 7'h4A,
    parameter int         FILTER_LEN  = 4,
    parameter int         TIMEOUT     = 65535
) (
    input  logic        bus_clk,
    input  logic        bus_rst,
    input  logic        scl_in,
    input  logic        sda_in,
    output logic        set_stb,
    output logic [7:0]  set_addr,
    output logic [31:0] set_data,
    output logic        frame_err,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, ADDR, REG, DATA, IGNORE} state_t;
    state_t      r_state, w_state;
    logic [1:0]  r_s1, r_s2, r_flt, r_prev;
    logic [3:0]  r_fcnt [2];
    logic [4:0]  r_cnt, w_cnt;
    logic [31:0] r_sh, w_sh, w_data;
    logic [7:0]  r_reg, w_reg, w_addr;
    logic        w_stb, w_err, w_mid, w_to;
    logic        w_scl_chg, w_scl_rise, w_start, w_stop;

    // bit 1 carries SCL, bit 0 carries SDA through the whole input path
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            r_s1      <= 2'b11;
            r_s2      <= 2'b11;
            r_flt     <= 2'b11;
            r_prev    <= 2'b11;
            r_fcnt[0] <= '0;
            r_fcnt[1] <= '0;
        end else begin
            r_s1   <= {scl_in, sda_in};
            r_s2   <= r_s1;
            r_prev <= r_flt;
            for (int i = 0; i < 2; i++) begin
                if (r_s2[i] == r_flt[i]) r_fcnt[i] <= '0;
                else if (r_fcnt[i] == 4'(FILTER_LEN - 1)) begin
                    r_flt[i]  <= r_s2[i];
                    r_fcnt[i] <= '0;
                end else r_fcnt[i] <= r_fcnt[i] + 4'd1;
            end
        end
    end

    // an SCL change in the same cycle masks START/STOP; bits use last cycle's SDA
    assign w_scl_chg  = r_flt[1] ^ r_prev[1];
    assign w_scl_rise = r_flt[1] & ~r_prev[1];
    assign w_start    = r_prev[1] & ~w_scl_chg & r_prev[0] & ~r_flt[0];
    assign w_stop     = r_prev[1] & ~w_scl_chg & ~r_prev[0] & r_flt[0];
    assign busy       = (r_state == ADDR) || (r_state == REG) || (r_state == DATA);
    assign w_mid      = (r_state == REG) || (r_state == DATA);

`ifdef SETTINGS_BUS_TIMEOUT_EN
    logic [31:0] r_to;
    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) r_to <= '0;
        else r_to <= (w_scl_chg || w_start || !busy) ? '0 : r_to + 32'd1;
    end
    assign w_to = busy && !w_scl_chg && !w_start && (r_to == 32'(TIMEOUT - 1));
`else
    assign w_to = 1'b0;
`endif

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_sh    = r_sh;
        w_reg   = r_reg;
        w_addr  = set_addr;
        w_data  = set_data;
        w_stb   = 1'b0;
        w_err   = 1'b0;
        if (w_start) begin
            w_state = ADDR;
            w_cnt   = '0;
            w_sh    = '0;
            w_err   = w_mid;
        end else if (w_stop) begin
            w_state = IDLE;
            w_err   = w_mid;
        end else if (w_to) begin
            w_state = IDLE;
            w_err   = w_mid;
        end else if (w_scl_rise && busy) begin
            w_sh  = {r_sh[30:0], r_prev[0]};
            w_cnt = r_cnt + 5'd1;
            case (r_state)
                ADDR: if (r_cnt == 5'd7) begin
                    w_cnt   = '0;
                    w_state = (w_sh[7:1] == DEVICE_ADDR && !w_sh[0]) ? REG : IGNORE;
                end
                REG: if (r_cnt == 5'd7) begin
                    w_cnt   = '0;
                    w_reg   = w_sh[7:0];
                    w_state = DATA;
                end
                DATA: if (r_cnt == 5'd31) begin
                    w_stb   = 1'b1;
                    w_addr  = r_reg;
                    w_data  = w_sh;
                    w_state = IGNORE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge bus_clk or posedge bus_rst) begin
        if (bus_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_sh      <= '0;
            r_reg     <= '0;
            set_stb   <= 1'b0;
            frame_err <= 1'b0;
            set_addr  <= '0;
            set_data  <= '0;
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_sh      <= w_sh;
            r_reg     <= w_reg;
            set_stb   <= w_stb;
            frame_err <= w_err;
            set_addr  <= w_addr;
            set_data  <= w_data;
        end
    end
endmodule

// File: tb/tb_fx3_settings_slave.sv
// tb_fx3_settings_slave: table-driven write frames plus glitch, repeated-START, stall and reset sequences.
`timescale 1ns/1ps
module tb_fx3_settings_slave;
    localparam int H = 16;
`ifdef SETTINGS_BUS_TIMEOUT_EN
    localparam int TO = 1000;
`else
    localparam int TO = 65535;
`endif

    logic        clk = 1'b0, rst = 1'b1, scl = 1'b1, sda = 1'b1;
    logic        set_stb, frame_err, busy;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    int          stb_cnt = 0, err_cnt = 0, both_cnt = 0, pass_cnt = 0, total_cnt = 0;
    time         t_fall = 0;

    fx3_settings_slave #(.DEVICE_ADDR(7'h4A), .FILTER_LEN(4), .TIMEOUT(TO)) dut (
        .bus_clk(clk), .bus_rst(rst), .scl_in(scl), .sda_in(sda),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (set_stb) stb_cnt++;
        if (frame_err) err_cnt++;
        if (set_stb && frame_err) both_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  dev, rg;
        logic [31:0] data;
        int          nd, e_stb, e_err;
        logic [7:0]  e_addr;
        logic [31:0] e_data;
        logic        e_busy;
    } vec_t;
    vec_t vt [7];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total_cnt++;
        if (a === e) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", n, a, e);
    endtask

    task automatic chk_rng(input string n, input longint a, input longint lo, input longint hi);
        total_cnt++;
        if (a >= lo && a <= hi) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d..%0d", n, a, lo, hi);
    endtask

    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_(input logic b, input bit g);
        sda = b;
        wt(H);
        if (g) begin
            scl = 1'b1;
            wt(2);
            scl = 1'b0;
            wt(H);
        end
        scl = 1'b1;
        wt(H);
        scl = 1'b0;
        t_fall = $time;
        wt(H);
    endtask

    task automatic byte_(input logic [7:0] v, input bit g);
        for (int i = 7; i >= 0; i--) bit_(v[i], g);
    endtask

    task automatic start_();
        sda = 1'b1; wt(H);
        scl = 1'b1; wt(H);
        sda = 1'b0; wt(H);
        scl = 1'b0; wt(H);
    endtask

    task automatic stop_();
        sda = 1'b0; wt(H);
        scl = 1'b1; wt(H);
        sda = 1'b1; wt(H);
    endtask

    task automatic word_(input logic [31:0] d, input bit g);
        for (int k = 0; k < 4; k++) byte_(8'(d >> (8 * (3 - k))), g);
    endtask

    initial begin
        vt[0] = '{8'h94, 8'h23, 32'hDEADBEEF, 4, 1, 0, 8'h23, 32'hDEADBEEF, 1'b1};
        vt[1] = '{8'h96, 8'h23, 32'hDEADBEEF, 4, 0, 0, 8'h23, 32'hDEADBEEF, 1'b0};
        vt[2] = '{8'h95, 8'h23, 32'hDEADBEEF, 4, 0, 0, 8'h23, 32'hDEADBEEF, 1'b0};
        vt[3] = '{8'h94, 8'h10, 32'hCAFEF00D, 2, 0, 1, 8'h23, 32'hDEADBEEF, 1'b1};
        vt[4] = '{8'h94, 8'h11, 32'h00000001, 4, 1, 0, 8'h11, 32'h00000001, 1'b1};
        vt[5] = '{8'h94, 8'hA5, 32'h80000001, 4, 1, 0, 8'hA5, 32'h80000001, 1'b1};
        vt[6] = '{8'h94, 8'h3C, 32'h12345678, 5, 1, 0, 8'h3C, 32'h12345678, 1'b1};

        wt(5);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stb", 32'(set_stb), 0);
        chk("rst_err", 32'(frame_err), 0);
        chk("rst_addr", 32'(set_addr), 0);
        chk("rst_data", set_data, 0);
        rst = 1'b0;
        wt(10);
        chk("idle_busy", 32'(busy), 0);

        for (int i = 0; i < 7; i++) begin
            stb_cnt = 0;
            err_cnt = 0;
            start_();
            byte_(vt[i].dev, 1'b0);
            wt(4);
            chk($sformatf("v%0d_busy_dev", i), 32'(busy), 32'(vt[i].e_busy));
            byte_(vt[i].rg, 1'b0);
            chk($sformatf("v%0d_hold_addr", i), 32'(set_addr), i == 0 ? 32'h0 : 32'(vt[i-1].e_addr));
            for (int k = 0; k < vt[i].nd; k++)
                byte_(k < 4 ? 8'(vt[i].data >> (8 * (3 - k))) : 8'h55, 1'b0);
            stop_();
            wt(10);
            chk($sformatf("v%0d_stb", i), 32'(stb_cnt), 32'(vt[i].e_stb));
            chk($sformatf("v%0d_err", i), 32'(err_cnt), 32'(vt[i].e_err));
            chk($sformatf("v%0d_addr", i), 32'(set_addr), 32'(vt[i].e_addr));
            chk($sformatf("v%0d_data", i), set_data, vt[i].e_data);
            chk($sformatf("v%0d_busy_end", i), 32'(busy), 0);
        end

        stb_cnt = 0; err_cnt = 0;
        start_();
        byte_(8'h94, 1'b0);
        byte_(8'h5C, 1'b0);
        word_(32'hA5C33C5A, 1'b1);
        stop_();
        wt(10);
        chk("glitch_stb", 32'(stb_cnt), 1);
        chk("glitch_err", 32'(err_cnt), 0);
        chk("glitch_addr", 32'(set_addr), 32'h5C);
        chk("glitch_data", set_data, 32'hA5C33C5A);

        stb_cnt = 0; err_cnt = 0;
        start_();
        byte_(8'h94, 1'b0);
        byte_(8'h22, 1'b0);
        byte_(8'h0B, 1'b0);
        byte_(8'hAD, 1'b0);
        start_();
        chk("rstart_err", 32'(err_cnt), 1);
        chk("rstart_busy", 32'(busy), 1);
        byte_(8'h94, 1'b0);
        byte_(8'h22, 1'b0);
        word_(32'h0BADF00D, 1'b0);
        stop_();
        wt(10);
        chk("rstart_stb", 32'(stb_cnt), 1);
        chk("rstart_err_total", 32'(err_cnt), 1);
        chk("rstart_addr", 32'(set_addr), 32'h22);
        chk("rstart_data", set_data, 32'h0BADF00D);

        stb_cnt = 0; err_cnt = 0;
        start_();
        byte_(8'h94, 1'b0);
        byte_(8'h77, 1'b0);
        byte_(8'h12, 1'b0);
`ifdef SETTINGS_BUS_TIMEOUT_EN
        begin
            bit got = 1'b0;
            for (int n = 0; n < 1500 && !got; n++) begin
                @(negedge clk);
                got = frame_err;
            end
            chk("to_seen", 32'(got), 1);
            chk_rng("to_latency", ($time - t_fall) / 10, 1005, 1009);
            chk("to_busy", 32'(busy), 0);
        end
        wt(10);
`else
        wt(1500);
        chk("stall_err", 32'(err_cnt), 0);
        chk("stall_busy", 32'(busy), 1);
`endif
        stop_();
        wt(10);
        chk("stall_err_total", 32'(err_cnt), 1);
        chk("stall_stb", 32'(stb_cnt), 0);
        chk("stall_busy_end", 32'(busy), 0);

        stb_cnt = 0; err_cnt = 0;
        start_();
        byte_(8'h94, 1'b0);
        byte_(8'h33, 1'b0);
        byte_(8'hAA, 1'b0);
        byte_(8'hBB, 1'b0);
        rst = 1'b1;
        wt(3);
        rst = 1'b0;
        wt(1);
        chk("mrst_busy", 32'(busy), 0);
        chk("mrst_addr", 32'(set_addr), 0);
        chk("mrst_data", set_data, 0);
        sda = 1'b1; wt(H);
        scl = 1'b1; wt(H);
        wt(20);
        chk("mrst_stb", 32'(stb_cnt), 0);
        chk("mrst_err", 32'(err_cnt), 0);
        start_();
        byte_(8'h94, 1'b0);
        byte_(8'h44, 1'b0);
        word_(32'h01020304, 1'b0);
        stop_();
        wt(10);
        chk("post_stb", 32'(stb_cnt), 1);
        chk("post_addr", 32'(set_addr), 32'h44);
        chk("post_data", set_data, 32'h01020304);
        chk("stb_err_overlap", 32'(both_cnt), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
